// File: rtl/w_demux_pkg.sv
// Shared constants, FSM encoding and lane helpers for the byte-to-word demux.
package w_demux_pkg;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int SEL_W  = $clog2(LANES);
    localparam int WORD_W = DATA_W * LANES;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] lane);
        return {{(LANES-1){1'b0}}, 1'b1} << lane;
    endfunction

    // Widen a per-lane enable into a per-bit mask over the word.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [WORD_W-1:0] mask;
        mask = {WORD_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            mask[l*DATA_W +: DATA_W] = {DATA_W{be[l]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/w_lane_decoder.sv
// Lane index to one-hot write enable, active only on an accepted byte.
module w_lane_decoder
    import w_demux_pkg::*;
(
    input  logic             i_accept,
    input  logic [SEL_W-1:0] i_lane,
    output logic [LANES-1:0] o_we
);

    // One-hot enable for the addressed lane, all-zero when nothing is accepted.
    always_comb begin
        if (i_accept) begin
            o_we = lane_onehot(i_lane);
        end else begin
            o_we = {LANES{1'b0}};
        end
    end

endmodule

// File: rtl/w_byte_demux.sv
// Steers lane-tagged bytes into a 32-bit word and presents it with byte enables.
// Optional W_DEMUX_AUTOLANE_EN: lane comes from an internal counter instead of in_lane.
module w_byte_demux
    import w_demux_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_lane,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [LANES-1:0]  out_be
);

    logic [0:0]        r_state;
    logic [WORD_W-1:0] r_word;
    logic [LANES-1:0]  r_be;

    logic              w_accept;
    logic              w_emit;
    logic [SEL_W-1:0]  w_lane;
    logic [LANES-1:0]  w_we;
    logic [WORD_W-1:0] w_mask;
    logic [WORD_W-1:0] w_word_base;
    logic [LANES-1:0]  w_be_base;
    logic [WORD_W-1:0] w_word_nxt;
    logic [LANES-1:0]  w_be_nxt;
    logic [0:0]        w_state_nxt;

    // In HOLD a new byte may only enter in the cycle the held word leaves.
    always_comb begin
        if (r_state == ST_HOLD) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_emit   = r_state[0] & out_ready;

`ifdef W_DEMUX_AUTOLANE_EN
    logic [SEL_W-1:0] r_lane_cnt;
    logic             w_unused_lane;

    assign w_unused_lane = ^in_lane;
    assign w_lane        = r_lane_cnt;

    // Auto lane pointer; an accepted byte takes priority so it can open the next word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lane_cnt <= {SEL_W{1'b0}};
        end else if (w_accept) begin
            r_lane_cnt <= in_last ? {SEL_W{1'b0}} : r_lane_cnt + {{(SEL_W-1){1'b0}}, 1'b1};
        end else if (w_emit) begin
            r_lane_cnt <= {SEL_W{1'b0}};
        end else begin
            r_lane_cnt <= r_lane_cnt;
        end
    end
`else
    assign w_lane = in_lane;
`endif

    w_lane_decoder u_lane_decoder (
        .i_accept (w_accept),
        .i_lane   (w_lane),
        .o_we     (w_we)
    );

    assign w_mask = lane_mask(w_we);

    // An emit clears the word first so a same-cycle byte starts the next word cleanly.
    always_comb begin
        if (w_emit) begin
            w_word_base = {WORD_W{1'b0}};
            w_be_base   = {LANES{1'b0}};
        end else begin
            w_word_base = r_word;
            w_be_base   = r_be;
        end
        w_word_nxt = (w_word_base & ~w_mask) | ({LANES{in_data}} & w_mask);
        w_be_nxt   = w_be_base | w_we;
    end

    // Word completes on in_last or once every lane has been written.
    always_comb begin
        if (w_accept) begin
            w_state_nxt = (in_last || (&w_be_nxt)) ? ST_HOLD : ST_FILL;
        end else if (w_emit) begin
            w_state_nxt = ST_FILL;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, word and enable registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FILL;
            r_word  <= {WORD_W{1'b0}};
            r_be    <= {LANES{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_be    <= w_be_nxt;
        end
    end

    assign out_valid = r_state[0];
    assign out_word  = r_word;
    assign out_be    = r_be;

endmodule
